// File: rtl/obstacle_scroll_engine.sv
// obstacle_scroll_engine
//   Multi-channel obstacle scroll engine with level timer. On every advancing
//   frame tick each of NUM_OBJ obstacle positions moves by its own step and
//   wraps at WRAP_LIMIT. game_time counts the advancing ticks, and the level
//   completes after LEVEL_LEN of them.
//
//   Optional feature macro: SPEED_RAMP_EN
//     Defined   : every channel's step is raised by a ramp stage
//                 r = min(game_time / RAMP_PERIOD, 3). The result saturates
//                 at 2**STEP_W - 1.
//     Undefined : the obj_step input is used exactly as given, and no ramp
//                 logic is built.
//
// Ports
//   clk                  in   system clock
//   reset                in   async active-high reset
//   tick                 in   frame-advance strobe (1 clk wide)
//   start                in   begin level (honoured only in IDLE)
//   pause                in   level-sensitive hold
//   menuScreen           in   clear request
//   playerWon            in   clear request
//   playerLost           in   clear request
//   obj_step             in   NUM_OBJ*STEP_W packed per-channel speeds
//   obj_position_counter out  NUM_OBJ*POS_W packed per-channel positions
//   game_time            out  advancing ticks elapsed in the current level
//   running              out  1 while in RUN
//   level_done           out  1-clk pulse on level completion
module obstacle_scroll_engine #(
    parameter int unsigned NUM_OBJ     = 4,
    parameter int unsigned POS_W       = 11,
    parameter int unsigned WRAP_LIMIT  = 700,
    parameter int unsigned STEP_W      = 4,
    parameter int unsigned TIME_W      = 11,
    parameter int unsigned LEVEL_LEN   = 200,
    parameter int unsigned RAMP_PERIOD = 50
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tick,
    input  logic                       start,
    input  logic                       pause,
    input  logic                       menuScreen,
    input  logic                       playerWon,
    input  logic                       playerLost,
    input  logic [NUM_OBJ*STEP_W-1:0]  obj_step,
    output logic [NUM_OBJ*POS_W-1:0]   obj_position_counter,
    output logic [TIME_W-1:0]          game_time,
    output logic                       running,
    output logic                       level_done
);

    localparam int unsigned SUM_W = POS_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Staggered start position of each channel: (i*WRAP_LIMIT)/NUM_OBJ.
    function automatic logic [NUM_OBJ*POS_W-1:0] home_vec();
        logic [NUM_OBJ*POS_W-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < NUM_OBJ; i++) begin
            v[i*POS_W +: POS_W] = POS_W'((i * WRAP_LIMIT) / NUM_OBJ);
        end
        return v;
    endfunction

    localparam logic [NUM_OBJ*POS_W-1:0] HOME = home_vec();

    // Elaboration-time parameter sanity checks.
    if (WRAP_LIMIT >= (64'd1 << POS_W) || WRAP_LIMIT == 0) begin : g_bad_wrap
        $error("WRAP_LIMIT must be in 1..2**POS_W-1");
    end
    if (LEVEL_LEN < 2 || LEVEL_LEN >= (64'd1 << TIME_W)) begin : g_bad_level
        $error("LEVEL_LEN must be in 2..2**TIME_W-1");
    end
    if (RAMP_PERIOD == 0 || NUM_OBJ == 0 || NUM_OBJ > 8) begin : g_bad_cfg
        $error("RAMP_PERIOD must be >= 1 and NUM_OBJ in 1..8");
    end

    state_t                     state;
    logic                       clear;
    logic                       terminal;
    logic [NUM_OBJ*STEP_W-1:0]  eff_step;
    logic [NUM_OBJ*POS_W-1:0]   pos_next;
    logic [SUM_W-1:0]           sum;

    assign clear    = menuScreen | playerWon | playerLost;
    assign terminal = (game_time == TIME_W'(LEVEL_LEN - 1));

`ifdef SPEED_RAMP_EN
    localparam int unsigned RAMP_CNT_W = (RAMP_PERIOD > 1) ? $clog2(RAMP_PERIOD) : 1;
    localparam int unsigned RS_W       = STEP_W + 1;
    localparam logic [RS_W-1:0] STEP_MAX = RS_W'((64'd1 << STEP_W) - 1);

    // ramp_cnt tracks game_time mod RAMP_PERIOD so no divider is needed.
    logic [RAMP_CNT_W-1:0] ramp_cnt;
    logic [1:0]            ramp_stage;
    logic [RS_W-1:0]       ramped;

    // Effective step: input step plus ramp stage, saturated to STEP_W bits.
    always_comb begin
        eff_step = obj_step;
        ramped   = '0;
        for (int unsigned i = 0; i < NUM_OBJ; i++) begin
            ramped = RS_W'(obj_step[i*STEP_W +: STEP_W]) + RS_W'(ramp_stage);
            if (ramped > STEP_MAX) begin
                ramped = STEP_MAX;
            end
            eff_step[i*STEP_W +: STEP_W] = ramped[STEP_W-1:0];
        end
    end
`else
    assign eff_step = obj_step;
`endif

    // Next positions: add the step in POS_W+1 bits, and wrap by one subtraction.
    // A single subtraction is enough because pos < WRAP_LIMIT and step < WRAP_LIMIT.
    always_comb begin
        pos_next = obj_position_counter;
        sum      = '0;
        for (int unsigned i = 0; i < NUM_OBJ; i++) begin
            sum = {1'b0, obj_position_counter[i*POS_W +: POS_W]}
                + SUM_W'(eff_step[i*STEP_W +: STEP_W]);
            if (sum >= SUM_W'(WRAP_LIMIT)) begin
                sum = sum - SUM_W'(WRAP_LIMIT);
            end
            pos_next[i*POS_W +: POS_W] = sum[POS_W-1:0];
        end
    end

    // Level FSM, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                <= IDLE;
            obj_position_counter <= HOME;
            game_time            <= '0;
            running              <= 1'b0;
            level_done           <= 1'b0;
`ifdef SPEED_RAMP_EN
            ramp_cnt             <= '0;
            ramp_stage           <= '0;
`endif
        end else begin
            level_done <= 1'b0;
            if (clear) begin
                state                <= IDLE;
                obj_position_counter <= HOME;
                game_time            <= '0;
                running              <= 1'b0;
`ifdef SPEED_RAMP_EN
                ramp_cnt             <= '0;
                ramp_stage           <= '0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    RUN: begin
                        // pause takes precedence over tick: nothing advances.
                        if (pause) begin
                            state   <= PAUSE;
                            running <= 1'b0;
                        end else if (tick) begin
                            obj_position_counter <= pos_next;
                            game_time            <= game_time + TIME_W'(1);
`ifdef SPEED_RAMP_EN
                            if (ramp_cnt == RAMP_CNT_W'(RAMP_PERIOD - 1)) begin
                                ramp_cnt <= '0;
                                if (ramp_stage != 2'd3) begin
                                    ramp_stage <= ramp_stage + 2'd1;
                                end
                            end else begin
                                ramp_cnt <= ramp_cnt + RAMP_CNT_W'(1);
                            end
`endif
                            if (terminal) begin
                                state      <= DONE;
                                running    <= 1'b0;
                                level_done <= 1'b1;
                            end
                        end
                    end
                    PAUSE: begin
                        if (!pause) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    DONE: begin
                        state <= DONE;
                    end
                    default: begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_obstacle_scroll_engine.sv
// Scoreboard testbench for obstacle_scroll_engine. Each cycle the driver
// updates a behavioural level model from the applied inputs and queues the
// expected outputs. A negedge monitor pops each entry and compares it with
// the DUT. Directed spot checks cover the documented scenarios, and a
// random phase follows them.
module tb_obstacle_scroll_engine;

    localparam int NUM_OBJ     = 4;
    localparam int POS_W       = 11;
    localparam int WRAP_LIMIT  = 700;
    localparam int STEP_W      = 4;
    localparam int TIME_W      = 11;
    localparam int LEVEL_LEN   = 200;
    localparam int RAMP_PERIOD = 50;
    localparam int STEP_MAX    = (1 << STEP_W) - 1;

    logic                      clk = 1'b0;
    logic                      reset, tick, start, pause;
    logic                      menuScreen, playerWon, playerLost;
    logic [NUM_OBJ*STEP_W-1:0] obj_step;
    logic [NUM_OBJ*POS_W-1:0]  obj_position_counter;
    logic [TIME_W-1:0]         game_time;
    logic                      running, level_done;

    always #5 clk = ~clk;

    obstacle_scroll_engine #(
        .NUM_OBJ(NUM_OBJ), .POS_W(POS_W), .WRAP_LIMIT(WRAP_LIMIT),
        .STEP_W(STEP_W), .TIME_W(TIME_W), .LEVEL_LEN(LEVEL_LEN),
        .RAMP_PERIOD(RAMP_PERIOD)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .pause(pause),
        .menuScreen(menuScreen), .playerWon(playerWon), .playerLost(playerLost),
        .obj_step(obj_step), .obj_position_counter(obj_position_counter),
        .game_time(game_time), .running(running), .level_done(level_done)
    );

    typedef struct {
        int pos [NUM_OBJ];
        int t;
        int run;
        int done;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Behavioural model: mode 0 idle, 1 running, 2 paused, 3 level over.
    int m_pos [NUM_OBJ];
    int m_time;
    int m_mode;
    int m_done;

    function automatic int home(input int i);
        return (i * WRAP_LIMIT) / NUM_OBJ;
    endfunction

    function automatic int dpos(input int i);
        return int'(obj_position_counter[i*POS_W +: POS_W]);
    endfunction

    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_update();
        int   r;
        int   eff;
        exp_t e;
        m_done = 0;
        if (reset || menuScreen || playerWon || playerLost) begin
            for (int i = 0; i < NUM_OBJ; i++) m_pos[i] = home(i);
            m_time = 0;
            m_mode = 0;
        end else begin
            case (m_mode)
                0: if (start) m_mode = 1;
                1: begin
                    if (pause) m_mode = 2;
                    else if (tick) begin
                        r = 0;
`ifdef SPEED_RAMP_EN
                        r = m_time / RAMP_PERIOD;
                        if (r > 3) r = 3;
`endif
                        for (int i = 0; i < NUM_OBJ; i++) begin
                            eff = int'(obj_step[i*STEP_W +: STEP_W]) + r;
                            if (eff > STEP_MAX) eff = STEP_MAX;
                            m_pos[i] = (m_pos[i] + eff) % WRAP_LIMIT;
                        end
                        m_time++;
                        if (m_time == LEVEL_LEN) begin
                            m_done = 1;
                            m_mode = 3;
                        end
                    end
                end
                2: if (!pause) m_mode = 1;
                default: ;
            endcase
        end
        for (int i = 0; i < NUM_OBJ; i++) e.pos[i] = m_pos[i];
        e.t    = m_time;
        e.run  = (m_mode == 1) ? 1 : 0;
        e.done = m_done;
        sb.push_back(e);
    endfunction

    // Apply the current inputs for one clock, and queue the model's expectation.
    task automatic step();
        model_update();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Monitor: outputs are registered and updated on each edge, so one
    // expectation is consumed per cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            for (int i = 0; i < NUM_OBJ; i++) chk($sformatf("sb_pos%0d", i), dpos(i), e.pos[i]);
            chk("sb_game_time", int'(game_time), e.t);
            chk("sb_running", int'(running), e.run);
            chk("sb_level_done", int'(level_done), e.done);
        end
    end

    initial begin
        int guard;
        int rst_pos [NUM_OBJ];
        int run_pos [NUM_OBJ];
        rst_pos = '{0, 175, 350, 525};
        run_pos = '{30, 205, 380, 555};

        reset = 1'b1; tick = 1'b0; start = 1'b0; pause = 1'b0;
        menuScreen = 1'b0; playerWon = 1'b0; playerLost = 1'b0;
        obj_step = '0;
        step();
        for (int i = 0; i < NUM_OBJ; i++) chk("reset_pos", dpos(i), rst_pos[i]);
        chk("reset_time", int'(game_time), 0);
        chk("reset_running", int'(running), 0);
        chk("reset_done", int'(level_done), 0);
        reset = 1'b0;

        // Start and three ticks at step 10.
        obj_step = {NUM_OBJ{4'd10}};
        start = 1'b1; step(); start = 1'b0;
        chk("start_running", int'(running), 1);
        tick = 1'b1;
        repeat (3) step();
        for (int i = 0; i < NUM_OBJ; i++) chk("three_tick_pos", dpos(i), run_pos[i]);
        chk("three_tick_time", int'(game_time), 3);

        // Move channel 3 to 695, then wrap it. Channel 0 is held at step 0.
        repeat (14) step();
        chk("ch3_pre_wrap", dpos(3), 695);
        obj_step[0 +: STEP_W] = '0;
        step();
        chk("ch3_wrap", dpos(3), 5);
        chk("ch0_hold", dpos(0), 170);
        chk("wrap_time", int'(game_time), 18);

        // Pause with ticks freezes everything.
        pause = 1'b1;
        repeat (5) step();
        chk("pause_time", int'(game_time), 18);
        chk("pause_running", int'(running), 0);
        pause = 1'b0; tick = 1'b0;
        step();
        tick = 1'b1; step(); tick = 1'b0;
        chk("resume_time", int'(game_time), 19);

        // Randomly run up to game_time 199.
        guard = 0;
        while (m_time < LEVEL_LEN - 1 && guard < 5000) begin
            obj_step = NUM_OBJ*STEP_W'($urandom);
            tick  = 1'($urandom_range(0, 1));
            pause = ($urandom_range(0, 7) == 0);
            step();
            guard++;
        end
        pause = 1'b0; tick = 1'b0;
        step(); step();
        chk("pre_terminal_time", int'(game_time), LEVEL_LEN - 1);
        tick = 1'b1; step(); tick = 1'b0;
        chk("terminal_time", int'(game_time), LEVEL_LEN);
        chk("terminal_done", int'(level_done), 1);
        chk("terminal_running", int'(running), 0);
        step();
        chk("done_pulse_end", int'(level_done), 0);
        tick = 1'b1; start = 1'b1;
        repeat (5) step();
        tick = 1'b0; start = 1'b0;
        chk("done_frozen_time", int'(game_time), LEVEL_LEN);

        // Clear from DONE, then playerLost together with tick mid-run.
        playerLost = 1'b1; step(); playerLost = 1'b0;
        chk("clear_done_time", int'(game_time), 0);
        start = 1'b1; step(); start = 1'b0;
        obj_step = {NUM_OBJ{4'd10}};
        tick = 1'b1;
        repeat (5) step();
        playerLost = 1'b1; step(); playerLost = 1'b0; tick = 1'b0;
        for (int i = 0; i < NUM_OBJ; i++) chk("lost_home", dpos(i), rst_pos[i]);
        chk("lost_time", int'(game_time), 0);
        chk("lost_running", int'(running), 0);

`ifdef SPEED_RAMP_EN
        start = 1'b1; step(); start = 1'b0;
        tick = 1'b1;
        repeat (51) step();
        tick = 1'b0;
        chk("ramp_pos0", dpos(0), 511);
        playerLost = 1'b1; step(); playerLost = 1'b0;
`endif

        // Random phase.
        repeat (3000) begin
            reset      = ($urandom_range(0, 1999) == 0);
            menuScreen = ($urandom_range(0, 1499) == 0);
            playerWon  = ($urandom_range(0, 1499) == 0);
            playerLost = ($urandom_range(0, 1499) == 0);
            start      = ($urandom_range(0, 7) == 0);
            pause      = ($urandom_range(0, 5) == 0);
            tick       = 1'($urandom_range(0, 1));
            obj_step   = NUM_OBJ*STEP_W'($urandom);
            step();
        end
        reset = 1'b0; menuScreen = 1'b0; playerWon = 1'b0; playerLost = 1'b0;
        start = 1'b0; pause = 1'b0; tick = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
